// File: rtl/player_motion_ctrl.sv
// Player vertical motion controller: gravity fall against scrolling platform lines.
// Explicit IDLE/FALL/LAND/DEAD FSM with accelerating fall, buffered gravity flips,
// screen-edge death and restart.
// Ports:
//   clk_i, rst_i (async, active-low)   clock and reset
//   player_en_i                        run enable, low parks the player in IDLE
//   grv_i                              gravity flip request (rising edge)
//   restart_i                          leave DEAD and reload the start state
//   lines_i                            line k occupancy at [k*SCREEN_W +: SCREEN_W]
//   luc_loc_o                          player bottom edge row
//   grv_o                              1 = gravity down, 0 = up
//   state_o                            0 IDLE, 1 FALL, 2 LAND, 3 DEAD
//   flip_ack_o                         one-cycle pulse when a flip is taken
//   dead_o                             high while in DEAD
module player_motion_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int YW           = 9,
    parameter int NUM_LINES    = 4,
    parameter logic [NUM_LINES*YW-1:0] LINE_LOCS =
        {9'd461, 9'd319, 9'd177, 9'd35},
    parameter int LINE_W       = 18,
    parameter int PLAYER_H     = 60,
    parameter int PLAYER_W     = 40,
    parameter int PLAYER_X     = 0,
    parameter int START_LOC    = 319,
    parameter int PERIOD_START = 4,
    parameter int PERIOD_MIN   = 1,
    parameter int FLIP_BUF     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          player_en_i,
    input  logic                          grv_i,
    input  logic                          restart_i,
    input  logic [NUM_LINES*SCREEN_W-1:0] lines_i,
    output logic [YW-1:0]                 luc_loc_o,
    output logic                          grv_o,
    output logic [1:0]                    state_o,
    output logic                          flip_ack_o,
    output logic                          dead_o
);

    localparam int PW = $clog2(PERIOD_START + 1);
    localparam int BW = (FLIP_BUF > 0) ? $clog2(FLIP_BUF + 1) : 1;

    localparam logic [PW-1:0] P_START = PW'(PERIOD_START);
    localparam logic [PW-1:0] P_MIN   = PW'(PERIOD_MIN);
    localparam logic [BW-1:0] P_BUF   = BW'(FLIP_BUF);
    localparam logic [YW-1:0] P_LOC   = YW'(START_LOC);
    localparam logic [YW:0]   UP_OFS  = (YW+1)'(LINE_W + PLAYER_H);
    localparam logic [YW:0]   BOT_LIM = (YW+1)'(SCREEN_H);
    localparam logic [YW:0]   TOP_LIM = (YW+1)'(PLAYER_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FALL = 2'd1,
        S_LAND = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [YW-1:0] loc, loc_n;
    logic          grv, grv_n;
    logic [PW-1:0] cnt, cnt_n;
    logic [PW-1:0] period, period_n;
    logic [BW-1:0] buf_cnt, buf_n;
    logic          grv_q;

    logic [NUM_LINES-1:0] hit_dn;
    logic [NUM_LINES-1:0] hit_up;
    logic [YW:0]          loc_x;
    logic                 contact;
    logic                 at_edge;
    logic                 rise;
    logic                 pending;
    logic                 take_flip;
    logic                 tick;
    logic                 unused_bits;

    // Only the player's columns matter; the rest of each bitmap is ignored.
    assign unused_bits = ^lines_i;

    // Widen by one bit so the up-contact sum never wraps.
    assign loc_x = {1'b0, loc};

    always_comb begin
        hit_dn = '0;
        hit_up = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            hit_dn[k] = (|lines_i[k*SCREEN_W+PLAYER_X +: PLAYER_W])
                && (loc_x == {1'b0, LINE_LOCS[k*YW +: YW]});
            hit_up[k] = (|lines_i[k*SCREEN_W+PLAYER_X +: PLAYER_W])
                && (loc_x == {1'b0, LINE_LOCS[k*YW +: YW]} + UP_OFS);
        end
    end

    assign contact   = grv ? |hit_dn : |hit_up;
    assign at_edge   = grv ? (loc_x == BOT_LIM) : (loc_x == TOP_LIM);
    assign rise      = grv_i & ~grv_q;
    assign pending   = (buf_cnt != '0);
    assign tick      = (cnt == period - 1'b1);
    // The buffer is cleared on every LAND cycle, so a pending press
    // can only trigger on the LAND entry cycle.
    assign take_flip = (state == S_LAND) & player_en_i & (rise | pending);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            loc     <= P_LOC;
            grv     <= 1'b1;
            cnt     <= '0;
            period  <= P_START;
            buf_cnt <= '0;
            grv_q   <= 1'b0;
        end else begin
            state   <= state_n;
            loc     <= loc_n;
            grv     <= grv_n;
            cnt     <= cnt_n;
            period  <= period_n;
            buf_cnt <= buf_n;
            grv_q   <= grv_i;
        end
    end

    always_comb begin
        state_n  = state;
        loc_n    = loc;
        grv_n    = grv;
        cnt_n    = cnt;
        period_n = period;
        buf_n    = buf_cnt;
        unique case (state)
            S_IDLE: begin
                cnt_n    = '0;
                period_n = P_START;
                buf_n    = '0;
                if (player_en_i) state_n = S_FALL;
            end
            S_FALL: begin
                if (rise)         buf_n = P_BUF;
                else if (pending) buf_n = buf_cnt - 1'b1;
                if (!player_en_i) begin
                    state_n = S_IDLE;
                end else if (contact) begin
                    state_n = S_LAND;
                end else if (tick) begin
                    cnt_n = '0;
                    if (at_edge) begin
                        state_n = S_DEAD;
                    end else begin
                        loc_n    = grv ? loc + 1'b1 : loc - 1'b1;
                        period_n = (period > P_MIN) ? period - 1'b1 : P_MIN;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_LAND: begin
                buf_n = '0;
                if (!player_en_i) begin
                    state_n = S_IDLE;
                end else if (take_flip) begin
                    grv_n    = ~grv;
                    cnt_n    = '0;
                    period_n = P_START;
                    state_n  = S_FALL;
                end else if (!contact) begin
                    cnt_n    = '0;
                    period_n = P_START;
                    state_n  = S_FALL;
                end
            end
            S_DEAD: begin
                if (restart_i) begin
                    state_n  = S_IDLE;
                    loc_n    = P_LOC;
                    grv_n    = 1'b1;
                    cnt_n    = '0;
                    period_n = P_START;
                    buf_n    = '0;
                end
            end
        endcase
    end

    always_comb begin
        luc_loc_o  = loc;
        grv_o      = grv;
        state_o    = state;
        flip_ack_o = take_flip;
        dead_o     = (state == S_DEAD);
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: expected output changes are queued
// by the stimulus and popped by a monitor whenever the DUT outputs change.
module tb_player_motion_ctrl;

    localparam int LW = 4 * 640;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          player_en_i;
    logic          grv_i;
    logic          restart_i;
    logic [LW-1:0] lines_i;
    logic [8:0]    luc_loc_o;
    logic          grv_o;
    logic [1:0]    state_o;
    logic          flip_ack_o;
    logic          dead_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [13:0] v;
        int          gap;
    } ev_t;

    ev_t q[$];

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .player_en_i (player_en_i),
        .grv_i       (grv_i),
        .restart_i   (restart_i),
        .lines_i     (lines_i),
        .luc_loc_o   (luc_loc_o),
        .grv_o       (grv_o),
        .state_o     (state_o),
        .flip_ack_o  (flip_ack_o),
        .dead_o      (dead_o)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] st, input int l, input logic g,
                        input logic a, input logic d, input int gap);
        ev_t e;
        e.v   = {st, 9'(l), g, a, d};
        e.gap = gap;
        q.push_back(e);
    endtask

    // One event per 1-px move; gaps follow the accelerating period.
    task automatic push_moves(input int start, input int dir, input int n);
        int p = 4;
        int l = start;
        for (int i = 0; i < n; i++) begin
            l = l + dir;
            push(2'd1, l, (dir > 0), 1'b0, 1'b0, p);
            p = (p > 1) ? p - 1 : 1;
        end
    endtask

    task automatic wait_for(input logic [1:0] st, input int l, input int budget);
        int n = 0;
        while (!(state_o == st && int'(luc_loc_o) == l) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_st%0d_loc%0d: state=%0d loc=%0d, required st=%0d loc=%0d",
                     st, l, state_o, luc_loc_o, st, l);
        end
    endtask

    initial begin : monitor
        logic [13:0] cur;
        logic [13:0] prev;
        int          cyc;
        int          last;
        bit          first;
        ev_t         e;
        first = 1'b1;
        cyc   = 0;
        last  = 0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {state_o, luc_loc_o, grv_o, flip_ack_o, dead_o};
            if (first || cur != prev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got st=%0d loc=%0d grv=%0b ack=%0b dead=%0b, required no change",
                             cur[13:12], cur[11:3], cur[2], cur[1], cur[0]);
                end else begin
                    e = q.pop_front();
                    if (cur != e.v || (e.gap != 0 && cyc - last != e.gap)) begin
                        n_bad++;
                        $display("FAIL event: got st=%0d loc=%0d grv=%0b ack=%0b dead=%0b gap=%0d, required st=%0d loc=%0d grv=%0b ack=%0b dead=%0b gap=%0d",
                                 cur[13:12], cur[11:3], cur[2], cur[1], cur[0], cyc - last,
                                 e.v[13:12], e.v[11:3], e.v[2], e.v[1], e.v[0], e.gap);
                    end
                end
                prev  = cur;
                last  = cyc;
                first = 1'b0;
            end
        end
    end

    initial begin : stim
        int n;
        rst_i       = 1'b0;
        player_en_i = 1'b0;
        grv_i       = 1'b0;
        restart_i   = 1'b0;
        lines_i     = '0;
        // reset state
        push(2'd0, 319, 1'b1, 1'b0, 1'b0, 0);
        tick(3);
        rst_i = 1'b1;
        // start on line 2, line 1 overhead
        lines_i[1*640 +: 40] = '1;
        lines_i[2*640 +: 40] = '1;
        push(2'd1, 319, 1'b1, 1'b0, 1'b0, 0);
        push(2'd2, 319, 1'b1, 1'b0, 1'b0, 1);
        player_en_i = 1'b1;
        tick(8);
        // flip up from LAND, rise to 255 under line 1
        push(2'd2, 319, 1'b1, 1'b1, 1'b0, 0);
        push(2'd1, 319, 1'b0, 1'b0, 1'b0, 1);
        push_moves(319, -1, 64);
        push(2'd2, 255, 1'b0, 1'b0, 1'b0, 1);
        grv_i = 1'b1;
        tick(1);
        grv_i = 1'b0;
        wait_for(2'd2, 255, 200);
        tick(3);
        // flip down; press 5 cycles before landing -> flip on LAND entry
        push(2'd2, 255, 1'b0, 1'b1, 1'b0, 0);
        push(2'd1, 255, 1'b1, 1'b0, 1'b0, 1);
        push_moves(255, 1, 64);
        push(2'd2, 319, 1'b1, 1'b1, 1'b0, 1);
        push(2'd1, 319, 1'b0, 1'b0, 1'b0, 1);
        push_moves(319, -1, 64);
        push(2'd2, 255, 1'b0, 1'b0, 1'b0, 1);
        grv_i = 1'b1;
        tick(1);
        grv_i = 1'b0;
        wait_for(2'd1, 314, 200);
        grv_i = 1'b1;
        tick(1);
        grv_i = 1'b0;
        // press 10 cycles before landing -> expired, stays LAND
        wait_for(2'd1, 265, 200);
        grv_i = 1'b1;
        tick(1);
        grv_i = 1'b0;
        wait_for(2'd2, 255, 200);
        tick(12);
        // lines vanish with gravity up -> die at the top edge
        push(2'd1, 255, 1'b0, 1'b0, 1'b0, 0);
        push_moves(255, -1, 195);
        push(2'd3, 60, 1'b0, 1'b0, 1'b1, 1);
        lines_i = '0;
        wait_for(2'd3, 60, 400);
        tick(3);
        // restart, fall down, drop enable at 330
        push(2'd0, 319, 1'b1, 1'b0, 1'b0, 0);
        push(2'd1, 319, 1'b1, 1'b0, 1'b0, 1);
        push_moves(319, 1, 11);
        push(2'd0, 330, 1'b1, 1'b0, 1'b0, 1);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        wait_for(2'd1, 330, 100);
        player_en_i = 1'b0;
        tick(5);
        // re-enable: period restarts at 4, die at the bottom edge
        push(2'd1, 330, 1'b1, 1'b0, 1'b0, 0);
        push_moves(330, 1, 150);
        push(2'd3, 480, 1'b1, 1'b0, 1'b1, 1);
        player_en_i = 1'b1;
        wait_for(2'd3, 480, 400);
        tick(3);
        push(2'd0, 319, 1'b1, 1'b0, 1'b0, 0);
        player_en_i = 1'b0;
        restart_i   = 1'b1;
        tick(1);
        restart_i = 1'b0;
        tick(3);
        // async reset mid-fall
        push(2'd1, 319, 1'b1, 1'b0, 1'b0, 0);
        push_moves(319, 1, 6);
        push(2'd0, 319, 1'b1, 1'b0, 1'b0, 1);
        player_en_i = 1'b1;
        wait_for(2'd1, 325, 50);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        n_vec++;
        if ({state_o, luc_loc_o, grv_o, dead_o} != {2'd0, 9'd319, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got st=%0d loc=%0d grv=%0b dead=%0b, required st=0 loc=319 grv=1 dead=0",
                     state_o, luc_loc_o, grv_o, dead_o);
        end
        player_en_i = 1'b0;
        tick(2);
        rst_i = 1'b1;
        tick(3);
        // all queued events must have been seen
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d events outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
